heartbeat_monitor: RTL
======================

Name: heartbeat_monitor

Overview:
Upstream stage of the core-switch/power-control block. It qualifies the raw toggling heartbeat pins from CPU A and CPU B and produces the clean level signals heartbeat_A and heartbeat_B that the switch logic consumes. A high level means the CPU is toggling at a legal rate. Each channel synchronises and glitch-filters its pin, measures the edge-to-edge interval, and runs a LOST/ACQ/ALIVE state machine. A channel is forced to LOST while its CPU is unpowered.

Parameters:
FILT_LEN, 16, cycles a synchronised level must be stable before it is accepted (min 1)
MIN_GAP, 50000, minimum legal cycles between filtered edges (1 ms at 50 MHz)
MAX_GAP, 25000000, maximum legal cycles between filtered edges (500 ms at 50 MHz); requires MAX_GAP > MIN_GAP
ACQ_EDGES, 4, consecutive legal intervals needed to declare ALIVE (min 1)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset; synchronous, active-high
hb_raw_A  in  1  asynchronous heartbeat pin from CPU A
hb_raw_B  in  1  asynchronous heartbeat pin from CPU B
power_on_A  in  1  CPU A powered (driven from cur_power_on_A_flag)
power_on_B  in  1  CPU B powered (driven from cur_power_on_B_flag)
heartbeat_A  out  1  1 = CPU A heartbeat valid
heartbeat_B  out  1  1 = CPU B heartbeat valid
hb_state_A  out  2  channel A state: 0 LOST, 1 ACQ, 2 ALIVE
hb_state_B  out  2  channel B state, same encoding

Behaviour:
- Reset: heartbeat_X=0; hb_state_X=LOST; synchroniser flops, filtered level, and the filter's stable level all 0; filter run counter 0; gap counter cnt=1; good_cnt=0.
- Channels A and B are identical and fully independent.
- Synchroniser: two-flop chain per pin, no reset dependence beyond clearing to 0.
- Filter: run counter counts cycles where the synchronised value differs from the filtered level. The filtered level flips when the count reaches FILT_LEN. Any match clears the counter.
- Latency: a clean raw transition reaches the filtered level 2+FILT_LEN cycles later.
- Edge: a flip of the filtered level, either polarity. One edge is at most one cycle.
- Gap counter cnt:
  - Loaded with 1 on the edge cycle; otherwise increments, saturating at MAX_GAP+1.
  - At an edge, cnt equals the distance in cycles to the previous edge.
  - Legal edge: MIN_GAP <= cnt <= MAX_GAP. Early edge: cnt < MIN_GAP.
  - Timeout: cnt == MAX_GAP with no edge that cycle; takes effect next cycle.
- State machine (registered; heartbeat_X = (state==ALIVE)):
  - LOST: any edge -> ACQ, good_cnt=0. That first edge is only a timing reference.
  - ACQ:
    - legal edge -> good_cnt+1; when the new value equals ACQ_EDGES -> ALIVE.
    - early edge -> stay in ACQ, good_cnt=0.
    - timeout -> LOST.
  - ALIVE: legal edge -> stay; early edge -> LOST; timeout -> LOST.
- power_on_X=0: state forced to LOST and good_cnt=0 every cycle.
  - Filter and gap counter keep running.
  - On power_on rising, acquisition restarts from LOST; the first edge after that is a reference only.
- Simultaneous events:
  - power_on_X=0 overrides edges.
  - A legal edge coinciding with cnt==MAX_GAP counts as legal, so no timeout.
- Widths:
  - cnt is $clog2(MAX_GAP+2) bits.
  - Filter counter is $clog2(FILT_LEN+1) bits.
  - good_cnt is $clog2(ACQ_EDGES+1) bits.
- rst asserted mid-operation returns everything to the reset values on the next edge.

Decomposition:
- Shared package/include holds the state encodings HB_LOST=2'd0, HB_ACQ=2'd1, HB_ALIVE=2'd2. 2'd3 is unused and decodes to LOST.
- Default timing constants are derived from the codebase's OSC define.
- One sub-module, hb_channel: synchroniser, filter, gap counter and FSM for a single pin. The top instantiates it twice.

Test Plan:
All scenarios use FILT_LEN=4, MIN_GAP=10, MAX_GAP=100, ACQ_EDGES=3.
- Reset, then hold hb_raw_A=0 with power_on_A=1 -> heartbeat_A=0 and hb_state_A=LOST for 300 cycles.
- Toggle hb_raw_A every 50 cycles -> state reaches ACQ on the filtered edge 6 cycles after the 1st toggle; ALIVE and heartbeat_A=1 at the 4th filtered edge.
- ALIVE, then stop toggling -> heartbeat_A falls exactly 101 cycles after the last filtered edge.
- ALIVE, then toggle 5 cycles after the previous edge -> LOST the following cycle. A 2-cycle glitch on hb_raw_A produces no edge and no state change.
- ALIVE, then power_on_A=0 for 1 cycle -> LOST. With toggling continuing at 50 cycles, ALIVE returns only after a reference edge plus 3 legal edges.
- A toggling at 50 cycles while B toggles at 5 cycles -> A ALIVE, B stays in ACQ with good_cnt=0. Assert rst mid-run -> both LOST next cycle.

Source files
------------

// File: rtl/heartbeat_monitor_pkg.sv
// heartbeat_monitor_pkg: state encodings and default timing shared by the heartbeat qualifier
`ifndef OSC
`define OSC 50000000
`endif

package heartbeat_monitor_pkg;

    typedef enum logic [1:0] {
        HB_LOST  = 2'd0,
        HB_ACQ   = 2'd1,
        HB_ALIVE = 2'd2
    } hb_state_e;

    localparam int OSC_HZ        = `OSC;
    localparam int DEF_FILT_LEN  = 16;
    localparam int DEF_MIN_GAP   = OSC_HZ / 1000;
    localparam int DEF_MAX_GAP   = OSC_HZ / 2;
    localparam int DEF_ACQ_EDGES = 4;

endpackage

// File: rtl/heartbeat_monitor_hb_channel.sv
// hb_channel: synchronises, glitch-filters and rate-qualifies one heartbeat pin
module hb_channel
    import heartbeat_monitor_pkg::*;
#(
    parameter int FILT_LEN  = DEF_FILT_LEN,
    parameter int MIN_GAP   = DEF_MIN_GAP,
    parameter int MAX_GAP   = DEF_MAX_GAP,
    parameter int ACQ_EDGES = DEF_ACQ_EDGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hb_raw_i,
    input  logic       power_on_i,
    output logic       heartbeat_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(MAX_GAP + 2);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int GW = $clog2(ACQ_EDGES + 1);
    localparam logic [CW-1:0] MIN_C  = CW'(MIN_GAP);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_GAP);
    localparam logic [FW-1:0] FILT_C = FW'(FILT_LEN);
    localparam logic [GW-1:0] ACQ_C  = GW'(ACQ_EDGES);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    hb_state_e     state_q, state_d;
    logic          mismatch, hb_edge, timeout, legal, early;

    // cnt saturates one past MAX_GAP, so cnt > MAX_GAP is the registered timeout
    always_comb begin
        mismatch = sync_q[1] != filt_q;
        hb_edge  = mismatch && (run_q + 1'b1 == FILT_C);
        filt_d   = filt_q ^ hb_edge;
        run_d    = (mismatch && !hb_edge) ? run_q + 1'b1 : '0;
        timeout  = cnt_q > MAX_C;
        cnt_d    = hb_edge ? CW'(1) : timeout ? cnt_q : cnt_q + 1'b1;
        legal    = hb_edge && cnt_q >= MIN_C && !timeout;
        early    = hb_edge && cnt_q < MIN_C;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            HB_LOST: begin
                if (hb_edge) begin
                    state_d = HB_ACQ;
                    good_d  = '0;
                end
            end
            HB_ACQ: begin
                if (timeout) begin
                    state_d = HB_LOST;
                end else if (legal) begin
                    good_d  = good_q + 1'b1;
                    state_d = (good_q + 1'b1 == ACQ_C) ? HB_ALIVE : HB_ACQ;
                end else if (early) begin
                    good_d = '0;
                end
            end
            HB_ALIVE: state_d = (timeout || early) ? HB_LOST : HB_ALIVE;
            default:  state_d = HB_LOST;
        endcase
        if (!power_on_i) begin
            state_d = HB_LOST;
            good_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            filt_q  <= 1'b0;
            run_q   <= '0;
            cnt_q   <= CW'(1);
            good_q  <= '0;
            state_q <= HB_LOST;
        end else begin
            sync_q  <= {sync_q[0], hb_raw_i};
            filt_q  <= filt_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            state_q <= state_d;
        end
    end

    assign heartbeat_o = state_q == HB_ALIVE;
    assign state_o     = state_q;

endmodule

// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: qualifies the CPU A and CPU B heartbeat pins into clean valid levels
module heartbeat_monitor
    import heartbeat_monitor_pkg::*;
#(
    parameter int FILT_LEN  = DEF_FILT_LEN,
    parameter int MIN_GAP   = DEF_MIN_GAP,
    parameter int MAX_GAP   = DEF_MAX_GAP,
    parameter int ACQ_EDGES = DEF_ACQ_EDGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hb_raw_A,
    input  logic       hb_raw_B,
    input  logic       power_on_A,
    input  logic       power_on_B,
    output logic       heartbeat_A,
    output logic       heartbeat_B,
    output logic [1:0] hb_state_A,
    output logic [1:0] hb_state_B
);

    hb_channel #(
        .FILT_LEN (FILT_LEN),
        .MIN_GAP  (MIN_GAP),
        .MAX_GAP  (MAX_GAP),
        .ACQ_EDGES(ACQ_EDGES)
    ) u_a (
        .clk        (clk),
        .rst        (rst),
        .hb_raw_i   (hb_raw_A),
        .power_on_i (power_on_A),
        .heartbeat_o(heartbeat_A),
        .state_o    (hb_state_A)
    );

    hb_channel #(
        .FILT_LEN (FILT_LEN),
        .MIN_GAP  (MIN_GAP),
        .MAX_GAP  (MAX_GAP),
        .ACQ_EDGES(ACQ_EDGES)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .hb_raw_i   (hb_raw_B),
        .power_on_i (power_on_B),
        .heartbeat_o(heartbeat_B),
        .state_o    (hb_state_B)
    );

endmodule
